pow2_lut_arbiter: RTL and testbench

- Shares one 5-to-9 pow2 (log-to-linear fraction) lookup between NUM_REQ requesters.
- Each requester presents a log-domain value: a signed integer part plus a 5-bit fraction.
- The block arbitrates round-robin, registers the winner, then performs the lookup in a second registered stage.
- It returns exponent, linear fraction and requester id on a single valid/ready output, with full backpressure.
- It sits between the log-domain accumulators and the float re-pack stage.

---
 rtl/pow2_lut_arbiter.sv | 144 ++++++++++++++
 tb/tb_pow2_lut_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow2_lut_arbiter.sv
// Round-robin front end that shares a single 32-entry pow2 fraction LUT among
// NUM_REQ log-domain requesters. It has two registered stages and valid/ready backpressure.

module pow2_req_lane #(
  parameter int INT_BITS = 6
) (
  input  logic                reset,
  input  logic                grant,
  input  logic                a_adv,
  input  logic [INT_BITS-1:0] slice_int,
  input  logic [4:0]          slice_frac,
  output logic                ready,
  output logic [INT_BITS-1:0] lane_int,
  output logic [4:0]          lane_frac
);
  // Ready is held low during reset so nothing is accepted into a pipeline that is being cleared.
  assign ready     = grant && a_adv && !reset;
  assign lane_int  = slice_int;
  assign lane_frac = slice_frac;
endmodule

module pow2_lut_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int INT_BITS = 6,
  parameter int ID_W     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*INT_BITS-1:0]  req_int,
  input  logic [NUM_REQ*5-1:0]         req_frac,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INT_BITS-1:0]          out_exp,
  output logic [8:0]                   out_frac,
  output logic [ID_W-1:0]              out_id,
  output logic                         busy
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [INT_BITS-1:0] lint;
    logic [4:0]          frac;
    logic [ID_W-1:0]     id;
  } a_stage_t;

  typedef struct packed {
    logic [INT_BITS-1:0] lexp;
    logic [8:0]          frac;
    logic [ID_W-1:0]     id;
  } b_stage_t;

  logic [NUM_REQ-1:0][INT_BITS-1:0] int_v;
  logic [NUM_REQ-1:0][4:0]          frac_v;
  logic [NUM_REQ-1:0]               grant;
  logic [ID_W-1:0]                  gnt_idx;
  logic [ID_W-1:0]                  ptr;
  logic [ID_W-1:0]                  sel;
  logic                             any_gnt;
  logic                             found;
  logic                             accept;
  logic                             a_adv;
  logic                             b_adv;
  logic [STAGES:1]                  vld_pipe;
  a_stage_t                         a_q;
  b_stage_t                         b_q;

  function automatic logic [8:0] pow2_lut(input logic [4:0] f);
    logic [8:0] v;
    v = 9'd0;
    case (f)
      5'd0:  v = 9'd0;    5'd1:  v = 9'd11;   5'd2:  v = 9'd23;   5'd3:  v = 9'd34;
      5'd4:  v = 9'd46;   5'd5:  v = 9'd59;   5'd6:  v = 9'd71;   5'd7:  v = 9'd84;
      5'd8:  v = 9'd97;   5'd9:  v = 9'd110;  5'd10: v = 9'd124;  5'd11: v = 9'd138;
      5'd12: v = 9'd152;  5'd13: v = 9'd167;  5'd14: v = 9'd181;  5'd15: v = 9'd197;
      5'd16: v = 9'd212;  5'd17: v = 9'd228;  5'd18: v = 9'd244;  5'd19: v = 9'd261;
      5'd20: v = 9'd278;  5'd21: v = 9'd295;  5'd22: v = 9'd313;  5'd23: v = 9'd331;
      5'd24: v = 9'd349;  5'd25: v = 9'd368;  5'd26: v = 9'd387;  5'd27: v = 9'd407;
      5'd28: v = 9'd427;  5'd29: v = 9'd448;  5'd30: v = 9'd469;  5'd31: v = 9'd490;
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  assign b_adv  = !vld_pipe[2] || out_ready;
  assign a_adv  = !vld_pipe[1] || b_adv;
  assign accept = any_gnt && a_adv && !reset;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    pow2_req_lane #(.INT_BITS(INT_BITS)) u_lane (
      .reset      (reset),
      .grant      (grant[i]),
      .a_adv      (a_adv),
      .slice_int  (req_int[i*INT_BITS +: INT_BITS]),
      .slice_frac (req_frac[i*5 +: 5]),
      .ready      (req_ready[i]),
      .lane_int   (int_v[i]),
      .lane_frac  (frac_v[i])
    );
  end

  // The scan starts one past the last winner. The pointer only moves on an accept,
  // so a requester that is waiting keeps its turn across stalls.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[sel]) begin
        found        = 1'b1;
        grant[sel]   = 1'b1;
        gnt_idx      = sel;
      end
    end
    any_gnt = found;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      ptr      <= ID_W'(NUM_REQ - 1);
    end else begin
      if (b_adv)  vld_pipe[2] <= vld_pipe[1];
      if (a_adv)  vld_pipe[1] <= any_gnt;
      if (accept) ptr         <= gnt_idx;
    end
  end

  // The data path has no reset. Its contents are ignored while the matching valid bit is low.
  always_ff @(posedge clock) begin
    if (a_adv) a_q <= '{lint: int_v[gnt_idx], frac: frac_v[gnt_idx], id: gnt_idx};
    if (b_adv) b_q <= '{lexp: a_q.lint, frac: pow2_lut(a_q.frac), id: a_q.id};
  end

  assign out_valid = vld_pipe[2];
  assign out_exp   = b_q.lexp;
  assign out_frac  = b_q.frac;
  assign out_id    = b_q.id;
  assign busy      = |vld_pipe;

endmodule

// File: tb/tb_pow2_lut_arbiter.sv
// Directed bench for pow2_lut_arbiter. Stimulus queues the expected results,
// and an output monitor pops each one and compares it when an output transfer happens.

module tb_pow2_lut_arbiter;
  localparam int N  = 4;
  localparam int IB = 6;
  localparam int IW = 2;

  typedef struct packed {
    logic [IB-1:0] e;
    logic [8:0]    f;
    logic [IW-1:0] id;
  } res_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][IB-1:0] int_a = '0;
  logic [N-1:0][4:0]    frac_a = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IB-1:0]     out_exp;
  logic [8:0]        out_frac;
  logic [IW-1:0]     out_id;
  logic              busy;

  res_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  int unsigned lut_tab [32] = '{
    0, 11, 23, 34, 46, 59, 71, 84,
    97, 110, 124, 138, 152, 167, 181, 197,
    212, 228, 244, 261, 278, 295, 313, 331,
    349, 368, 387, 407, 427, 448, 469, 490};

  pow2_lut_arbiter #(.NUM_REQ(N), .INT_BITS(IB), .ID_W(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_int   (int_a),
    .req_frac  (frac_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clock);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_idle", 32'(busy), 0);
    chk("sb_empty", sb.size(), 0);
    tick;
  endtask

  // output monitor
  initial begin
    res_t e;
    forever begin
      @(negedge clock);
      if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL out_unexpected: got exp=%0d frac=%0d id=%0d expected none", out_exp, out_frac, out_id);
        end else begin
          e = sb.pop_front();
          chk("out_result", {out_exp, out_frac, out_id}, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [IB-1:0] rr_int [4];
    logic [4:0]    rr_frac [4];
    int unsigned   rr_lut [4];
    int k;

    // reset state
    req_valid = '1;
    out_ready = 1'b1;
    tick;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    tick;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clock);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    tick;

    // single request: -3, frac 16
    do_reset;
    out_ready = 1'b1;
    int_a[2] = 6'h3D;
    frac_a[2] = 5'd16;
    req_valid = 4'b0100;
    @(negedge clock);
    chk("single_ready", 32'(req_ready), 32'b0100);
    sb.push_back({6'h3D, 9'd212, 2'd2});
    tick;
    req_valid = '0;
    @(negedge clock);
    chk("single_c1_valid", 32'(out_valid), 0);
    chk("single_c1_busy", 32'(busy), 1);
    tick;
    @(negedge clock);
    chk("single_c2_valid", 32'(out_valid), 1);
    tick;
    @(negedge clock);
    chk("single_c3_valid", 32'(out_valid), 0);
    drain;

    // round robin, all four valid
    do_reset;
    rr_int  = '{6'd5, 6'h3F, 6'd0, 6'd31};
    rr_frac = '{5'd0, 5'd1, 5'd16, 5'd31};
    rr_lut  = '{0, 11, 212, 490};
    for (int i = 0; i < N; i++) begin
      int_a[i] = rr_int[i];
      frac_a[i] = rr_frac[i];
    end
    out_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      sb.push_back({rr_int[c % 4], 9'(rr_lut[c % 4]), 2'(c % 4)});
      tick;
    end
    req_valid = '0;
    drain;

    // backpressure: requester 1 streams while the output is stalled
    do_reset;
    out_ready = 1'b0;
    int_a[1] = 6'd1;
    frac_a[1] = 5'd3;
    req_valid = 4'b0010;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(negedge clock);
      if (c < 5) chk("bp_ready", 32'(req_ready), (c < 2) ? 32'b0010 : 32'b0);
      if (c >= 2 && c < 5) begin
        chk("bp_hold", {out_valid, out_exp, out_frac, out_id}, {1'b1, 6'd1, 9'd34, 2'd1});
        chk("bp_busy", 32'(busy), 1);
      end
      if (req_ready[1]) begin
        case (k)
          0: sb.push_back({6'd1, 9'd34, 2'd1});
          1: sb.push_back({6'd2, 9'd110, 2'd1});
          default: sb.push_back({6'd3, 9'd278, 2'd1});
        endcase
        k++;
      end
      tick;
      case (k)
        1: begin int_a[1] = 6'd2; frac_a[1] = 5'd9; end
        2: begin int_a[1] = 6'd3; frac_a[1] = 5'd20; end
        default: req_valid = '0;
      endcase
      if (c == 4) out_ready = 1'b1;
    end
    chk("bp_accepts", k, 3);
    req_valid = '0;
    drain;

    // pointer hold across a stall
    do_reset;
    out_ready = 1'b0;
    int_a[3] = 6'd7;
    frac_a[3] = 5'd8;
    req_valid = 4'b1000;
    @(negedge clock);
    chk("ph_fill0", 32'(req_ready), 32'b1000);
    sb.push_back({6'd7, 9'd97, 2'd3});
    tick;
    int_a[3] = 6'd8;
    frac_a[3] = 5'd24;
    @(negedge clock);
    chk("ph_fill1", 32'(req_ready), 32'b1000);
    sb.push_back({6'd8, 9'd349, 2'd3});
    tick;
    int_a[3] = 6'd9;
    frac_a[3] = 5'd31;
    int_a[0] = 6'h38;
    frac_a[0] = 5'd5;
    req_valid = 4'b1001;
    repeat (3) begin
      @(negedge clock);
      chk("ph_stalled", 32'(req_ready), 0);
      tick;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("ph_first", 32'(req_ready), 32'b0001);
    sb.push_back({6'h38, 9'd59, 2'd0});
    tick;
    req_valid = 4'b1000;
    @(negedge clock);
    chk("ph_second", 32'(req_ready), 32'b1000);
    sb.push_back({6'd9, 9'd490, 2'd3});
    tick;
    req_valid = '0;
    drain;

    // full LUT sweep from requester 0
    do_reset;
    out_ready = 1'b1;
    req_valid = 4'b0001;
    for (int f = 0; f < 32; f++) begin
      frac_a[0] = 5'(f);
      int_a[0] = 6'(2 * f + 1);
      @(negedge clock);
      chk("lut_ready", 32'(req_ready), 32'b0001);
      sb.push_back({6'(2 * f + 1), 9'(lut_tab[f]), 2'd0});
      tick;
    end
    req_valid = '0;
    drain;

    // reset with both stages full
    do_reset;
    out_ready = 1'b0;
    int_a[2] = 6'd3;
    frac_a[2] = 5'd1;
    req_valid = 4'b0100;
    @(negedge clock);
    chk("mr_fill0", 32'(req_ready), 32'b0100);
    tick;
    frac_a[2] = 5'd2;
    @(negedge clock);
    chk("mr_fill1", 32'(req_ready), 32'b0100);
    tick;
    req_valid = '0;
    @(negedge clock);
    chk("mr_full", {30'd0, out_valid, busy}, 32'b11);
    tick;
    reset = 1'b1;
    int_a[0] = 6'h20;
    frac_a[0] = 5'd31;
    req_valid = '1;
    @(negedge clock);
    chk("mr_rst_ready", 32'(req_ready), 0);
    tick;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_grant0", 32'(req_ready), 32'b0001);
    sb.push_back({6'h20, 9'd490, 2'd0});
    tick;
    req_valid = '0;
    drain;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
